iomem_sevenseg: RTL and testbench

- Memory-mapped 4-digit seven-segment display controller on the PicoSoC iomem bus, in the 0x04xxxxxx region next to the GPIO/LED region at 0x03.
- Holds display registers written by firmware and time-multiplexes the Basys3 common-anode display (seg/dp/an, all active-low).
- Runs in the SoC clock domain (PLL CLKOUT0).

---
 rtl/sevenseg_pkg.sv | 48 ++++
 rtl/sevenseg_scan.sv | 46 ++++
 rtl/iomem_sevenseg.sv | 186 ++++++++++++++++++
 tb/tb_iomem_sevenseg.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared constants and helpers for the iomem seven-segment
//               controller: register offsets (iomem_addr[3:2]), CTRL bit
//               positions and the hex-to-segment encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    // Register offsets, taken from iomem_addr[3:2]
    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_RAW    = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // CTRL register layout
    localparam int CTRL_EN_LSB  = 0;   // [3:0] per-digit enable
    localparam int CTRL_DP_LSB  = 4;   // [7:4] per-digit decimal point
    localparam int CTRL_RAW_BIT = 8;   // [8]   raw segment mode
    localparam int CTRL_WIDTH   = 9;

    // Active-high segment pattern, bit order gfedcba
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_scan.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_scan
// Description : Digit scan timebase. A prescaler counts 0..DIV-1; on its last
//               count the digit index advances 0->1->2->3->0. o_frame_tick
//               marks the tick that wraps the index from 3 back to 0.
// Ports       : clk          - clock, rising edge
//               rst          - synchronous active-high reset
//               o_index      - current digit index
//               o_frame_tick - one-cycle pulse on the last digit's tick
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_scan #(
    parameter int DIV = 12500
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] o_index,
    output logic       o_frame_tick
);

    localparam int              c_PW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [c_PW-1:0] c_LAST = c_PW'(DIV - 1);

    logic [c_PW-1:0] r_presc;
    logic [1:0]      r_index;
    logic            w_tick;

    assign w_tick       = (r_presc == c_LAST);
    assign o_index      = r_index;
    assign o_frame_tick = w_tick && (r_index == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_index <= 2'd0;
        end else if (w_tick) begin
            r_presc <= '0;
            r_index <= r_index + 2'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/iomem_sevenseg.sv
`default_nettype none
// ============================================================================
// Module      : iomem_sevenseg
// Description : PicoSoC iomem slave driving a 4-digit common-anode seven-
//               segment display. Holds DATA/CTRL/RAW registers plus a
//               read-only STATUS word, and time-multiplexes the digits.
// Ports       : clk, reset               - clock / synchronous active-high reset
//               iomem_valid/ready        - request / one-cycle acknowledge
//               iomem_wstrb/addr/wdata   - byte strobes (0 = read), address,
//                                          write data
//               iomem_rdata              - read data, valid with iomem_ready
//               seg/dp/an                - active-low display pins
// Revision    : 1.0 - initial release
// ============================================================================
module iomem_sevenseg
    import sevenseg_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 50000000,
    parameter int         REFRESH_HZ  = 1000,
    parameter logic [7:0] ADDR_BASE   = 8'h04
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    output logic        iomem_ready,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an
);

    // Cycles each digit stays lit; must be at least 2.
    localparam int c_DIV = CLK_FREQ_HZ / (4 * REFRESH_HZ);

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic [15:0]           r_data;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic [27:0]           r_raw;
    logic                  r_frame;
    logic [6:0]            r_seg;
    logic                  r_dp;
    logic [3:0]            r_an;

    logic [1:0]  w_index;
    logic        w_frame_tick;
    logic        w_sel;
    logic        w_rd;
    logic [1:0]  w_off;
    logic [31:0] w_rdval;

    sevenseg_scan #(
        .DIV (c_DIV)
    ) u_scan (
        .clk          (clk),
        .rst          (reset),
        .o_index      (w_index),
        .o_frame_tick (w_frame_tick)
    );

    // The !r_ready term forces a one-cycle gap so a held valid is not
    // acknowledged twice.
    assign w_sel = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_BASE);
    assign w_rd  = (iomem_wstrb == 4'b0000);
    assign w_off = iomem_addr[3:2];

    // Remaining address and data bits have no meaning in this block.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, iomem_addr[23:4], iomem_addr[1:0], iomem_wdata[31:28]};

    always_comb begin
        w_rdval = 32'h0;
        case (w_off)
            OFF_DATA:   w_rdval = {16'h0, r_data};
            OFF_CTRL:   w_rdval = {{(32-CTRL_WIDTH){1'b0}}, r_ctrl};
            OFF_RAW:    w_rdval = {4'h0, r_raw};
            default:    w_rdval = {29'h0, r_frame, w_index};
        endcase
    end

    // ------------------------------------------------------------------
    // Bus handshake and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
            r_data  <= 16'h0;
            r_ctrl  <= '0;
            r_raw   <= 28'h0;
            r_frame <= 1'b0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rdval : 32'h0;

            if (w_sel) begin
                case (w_off)
                    OFF_DATA: begin
                        if (iomem_wstrb[0]) r_data[7:0]  <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) r_data[15:8] <= iomem_wdata[15:8];
                    end
                    OFF_CTRL: begin
                        if (iomem_wstrb[0]) r_ctrl[7:0]          <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) r_ctrl[CTRL_RAW_BIT] <= iomem_wdata[CTRL_RAW_BIT];
                    end
                    OFF_RAW: begin
                        if (iomem_wstrb[0]) r_raw[7:0]   <= iomem_wdata[7:0];
                        if (iomem_wstrb[1]) r_raw[15:8]  <= iomem_wdata[15:8];
                        if (iomem_wstrb[2]) r_raw[23:16] <= iomem_wdata[23:16];
                        if (iomem_wstrb[3]) r_raw[27:24] <= iomem_wdata[27:24];
                    end
                    default: ; // STATUS is read-only
                endcase
            end

            // A frame completing in the same cycle as a STATUS read wins.
            if (w_frame_tick) begin
                r_frame <= 1'b1;
            end else if (w_sel && w_rd && (w_off == OFF_STATUS)) begin
                r_frame <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: registered from the current index and registers
    // ------------------------------------------------------------------
    logic [3:0] w_nib;
    logic [6:0] w_raw7;
    logic       w_en;
    logic       w_dp_on;
    logic [3:0] w_en_v;
    logic [3:0] w_dp_v;
    logic [6:0] w_seg_n;
    logic [3:0] w_an_n;

    assign w_en_v  = r_ctrl[CTRL_EN_LSB +: 4];
    assign w_dp_v  = r_ctrl[CTRL_DP_LSB +: 4];
    assign w_en    = w_en_v[w_index];
    assign w_dp_on = w_dp_v[w_index];

    always_comb begin
        w_nib  = 4'h0;
        w_raw7 = 7'h00;
        case (w_index)
            2'd0: begin w_nib = r_data[3:0];   w_raw7 = r_raw[6:0];   end
            2'd1: begin w_nib = r_data[7:4];   w_raw7 = r_raw[13:7];  end
            2'd2: begin w_nib = r_data[11:8];  w_raw7 = r_raw[20:14]; end
            default: begin w_nib = r_data[15:12]; w_raw7 = r_raw[27:21]; end
        endcase

        if (!w_en) begin
            w_seg_n = 7'h7F;
        end else if (r_ctrl[CTRL_RAW_BIT]) begin
            w_seg_n = ~w_raw7;
        end else begin
            w_seg_n = ~hex7(w_nib);
        end

        w_an_n          = 4'hF;
        w_an_n[w_index] = ~w_en;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_an  <= 4'hF;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else begin
            r_an  <= w_an_n;
            r_seg <= w_seg_n;
            r_dp  <= ~(w_dp_on & w_en);
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign an          = r_an;

endmodule
`default_nettype wire

// File: tb/tb_iomem_sevenseg.sv
`default_nettype none
// ============================================================================
// Module      : tb_iomem_sevenseg
// Description : Scoreboard bench for iomem_sevenseg at DIV=4. A cycle model
//               pushes the expected read data whenever a request is accepted;
//               a monitor pops it on iomem_ready and also checks the display
//               pins every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iomem_sevenseg;

    localparam int CLK_HZ = 400;
    localparam int REF_HZ = 25;
    localparam int DIV    = CLK_HZ / (4 * REF_HZ);

    logic        clk;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    iomem_sevenseg #(
        .CLK_FREQ_HZ (CLK_HZ),
        .REFRESH_HZ  (REF_HZ),
        .ADDR_BASE   (8'h04)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .seg         (seg),
        .dp          (dp),
        .an          (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    int          ready_seen = 0;

    // ------------------------------------------------------------------
    // Reference model: registers are plain words with writable masks,
    // the scan position is derived from the cycle count since reset.
    // ------------------------------------------------------------------
    logic [31:0] m_reg[3];
    logic        m_frame;
    logic        m_ready;
    logic        m_live = 1'b0;
    int          m_t;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;

    function automatic logic [6:0] seg_of(input int v);
        logic [6:0] t[16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[v];
    endfunction

    initial begin : model
        int          idx;
        int          off;
        logic        sel;
        logic        en;
        logic [31:0] rv;
        logic [31:0] bm;
        logic [31:0] wmask[3];
        wmask = '{32'h0000_FFFF, 32'h0000_01FF, 32'h0FFF_FFFF};
        forever begin
            @(posedge clk);
            if (reset) begin
                m_reg   = '{32'h0, 32'h0, 32'h0};
                m_frame = 1'b0;
                m_ready = 1'b0;
                m_t     = 0;
                m_live  = 1'b1;
                exp_an  = 4'hF;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else if (m_live) begin
                idx = (m_t / DIV) % 4;
                en  = m_reg[1][idx];
                exp_an      = 4'hF;
                exp_an[idx] = ~en;
                if (!en)              exp_seg = 7'h7F;
                else if (m_reg[1][8]) exp_seg = ~m_reg[2][idx*7 +: 7];
                else                  exp_seg = ~seg_of(int'(m_reg[0][idx*4 +: 4]));
                exp_dp = ~(m_reg[1][4+idx] & en);

                sel = iomem_valid && !m_ready && (iomem_addr[31:24] == 8'h04);
                off = int'(iomem_addr[3:2]);
                if (sel) begin
                    if (off == 3) rv = {29'h0, m_frame, 2'(idx)};
                    else          rv = m_reg[off];
                    exp_q.push_back(rv);
                    if (iomem_wstrb != 4'h0 && off != 3) begin
                        bm = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (iomem_wstrb[b]) bm[b*8 +: 8] = 8'hFF;
                        m_reg[off] = ((m_reg[off] & ~bm) | (iomem_wdata & bm)) & wmask[off];
                    end
                end
                if ((m_t % DIV) == DIV - 1 && idx == 3)
                    m_frame = 1'b1;
                else if (sel && iomem_wstrb == 4'h0 && off == 3)
                    m_frame = 1'b0;
                m_ready = sel;
                m_t++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pins every cycle, read data on every acknowledge
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        prev_ready;
        logic [31:0] e;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (m_live) begin
                n_tests++;
                if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                    n_fail++;
                    $display("FAIL pins t=%0t: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                             $time, an, seg, dp, exp_an, exp_seg, exp_dp);
                end
            end
            if (iomem_ready === 1'b1) begin
                ready_seen++;
                n_tests++;
                if (prev_ready) begin
                    n_fail++;
                    $display("FAIL ready_b2b t=%0t: ready high 2 cycles, expected 1", $time);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ready t=%0t: rdata=%h, expected no ready", $time, iomem_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (iomem_rdata !== e) begin
                        n_fail++;
                        $display("FAIL rdata t=%0t: got %h, expected %h", $time, iomem_rdata, e);
                    end
                end
            end
            prev_ready = (iomem_ready === 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, expv);
        end
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                       input logic [31:0] wdata, output logic [31:0] rdata);
        bit got;
        @(negedge clk);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wdata;
        got   = 1'b0;
        rdata = 32'hx;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            if (iomem_ready === 1'b1) begin
                got   = 1'b1;
                rdata = iomem_rdata;
            end
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL bus_timeout addr=%h: no ready within 8 cycles, expected one", addr);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] d, input logic [3:0] strb = 4'hF);
        logic [31:0] dummy;
        bus({8'h04, 20'h0, off[1:0], 2'b00}, strb, d, dummy);
    endtask

    task automatic rd(input logic [3:0] off, output logic [31:0] d);
        bus({8'h04, 20'h0, off[1:0], 2'b00}, 4'h0, 32'h0, d);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Directed and random sequences
    // ------------------------------------------------------------------
    initial begin : stim
        logic [31:0] d;
        logic [31:0] rnd;
        int          cnt[4];
        int          n_off;
        int          n_ok0;
        int          r0;
        logic [3:0]  an_tab[4];
        logic [6:0]  seg_tab[4];
        an_tab  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_tab = '{7'h19, 7'h30, 7'h24, 7'h79};

        reset       = 1'b1;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_an",    {28'h0, an}, 32'hF);
        check("reset_seg",   {25'h0, seg}, 32'h7F);
        check("reset_dp",    {31'h0, dp}, 32'h1);
        check("reset_ready", {31'h0, iomem_ready}, 32'h0);
        reset = 1'b0;
        rd(4'd0, d); check("reset_data", d, 32'h0);
        rd(4'd1, d); check("reset_ctrl", d, 32'h0);
        rd(4'd2, d); check("reset_raw",  d, 32'h0);
        rd(4'd3, d); check("reset_status", d & 32'hFFFF_FFFC, 32'h0);

        // Hex display: each digit held DIV cycles over one frame
        wr(4'd0, 32'h1234);
        wr(4'd1, 32'h00F);
        repeat (3) @(negedge clk);
        cnt = '{0, 0, 0, 0};
        for (int c = 0; c < 4 * DIV; c++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++)
                if (an == an_tab[k] && seg == seg_tab[k]) cnt[k]++;
        end
        for (int k = 0; k < 4; k++)
            check($sformatf("hex_digit%0d_cycles", k), cnt[k], DIV);

        // Byte strobes
        wr(4'd0, 32'hAAAA, 4'h1);
        rd(4'd0, d); check("strobe_data", d, 32'h12AA);
        wr(4'd1, 32'h100, 4'h2);
        rd(4'd1, d); check("strobe_ctrl", d, 32'h10F);

        // Raw mode with decimal point on digit 0 only
        wr(4'd2, 32'h000007F);
        wr(4'd1, 32'h1F1);
        repeat (3) @(negedge clk);
        n_off = 0; n_ok0 = 0;
        for (int c = 0; c < 4 * DIV; c++) begin
            @(negedge clk);
            if (an == 4'hE && seg == 7'h00 && dp == 1'b0) n_ok0++;
            if (an == 4'hF && seg == 7'h7F && dp == 1'b1) n_off++;
        end
        check("raw_digit0_cycles", n_ok0, DIV);
        check("raw_blank_cycles",  n_off, 3 * DIV);

        // Held valid: acknowledge every other cycle
        @(negedge clk);
        r0 = ready_seen;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'h0;
        repeat (6) @(negedge clk);
        iomem_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("burst_ready_count", ready_seen - r0, 3);

        // Foreign region
        r0 = ready_seen;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0300_0000;
        repeat (6) @(negedge clk);
        iomem_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("foreign_no_ready", ready_seen - r0, 0);

        // Frame latch: set after a full frame, cleared by reading
        rd(4'd3, d);
        repeat (4 * DIV) @(negedge clk);
        for (int c = 0; c < 4 * DIV && (m_t % (4 * DIV)) != 1; c++) @(negedge clk);
        rd(4'd3, d); check("frame_set",   {31'h0, d[2]}, 32'h1);
        rd(4'd3, d); check("frame_clear", {31'h0, d[2]}, 32'h0);

        // Reset while a request is pending
        wr(4'd0, 32'hBEEF);
        @(negedge clk);
        r0 = ready_seen;
        iomem_valid = 1'b1;
        iomem_addr  = 32'h0400_0000;
        iomem_wstrb = 4'h0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        reset       = 1'b0;
        iomem_valid = 1'b0;
        check("reset_drops_req", ready_seen - r0, 0);
        rd(4'd0, d); check("post_reset_data", d, 32'h0);
        rd(4'd1, d); check("post_reset_ctrl", d, 32'h0);
        rd(4'd2, d); check("post_reset_raw",  d, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            rnd = $urandom();
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                iomem_valid = 1'b1;
                iomem_addr  = {(rnd[31:24] == 8'h04) ? 8'h05 : rnd[31:24], rnd[23:0]};
                iomem_wstrb = 4'h0;
                repeat (2) @(negedge clk);
                iomem_valid = 1'b0;
            end else begin
                d = $urandom();
                bus({8'h04, rnd[23:0]},
                    ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                    d, d);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
